// File: rtl/mem_arbiter.sv
// Arbitrates the single-port data memory between the MEM-stage core port and the
// debug/DMA loader port, sequencing fixed-latency reads and single-cycle writes.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t        state;
  logic [2:0]    lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          owner_dbg;

  logic idle;
  logic core_elig;
  logic dbg_elig;
  logic starved;
  logic core_win;
  logic dbg_win;

  // Core is ineligible in its own completion cycle so a held request is not re-issued.
  assign idle      = (state == IDLE);
  assign core_elig = ~reset & idle & core_req & ~core_rvalid;
  assign dbg_elig  = ~reset & idle & dbg_req;
  assign starved   = (starve_cnt >= SW'(STARVE_MAX));
  assign dbg_win   = dbg_elig & (~core_elig | starved);
  assign core_win  = core_elig & ~dbg_win;

  assign mem_en    = core_win | dbg_win;
  assign mem_we    = (core_win & core_we) | (dbg_win & dbg_we);
  assign mem_addr  = dbg_win ? dbg_addr : core_addr;
  assign mem_wdata = dbg_win ? dbg_wdata : core_wdata;
  assign dbg_gnt   = dbg_win;
  assign busy      = ~idle;

  // A granted core write completes immediately, so it never stalls in its grant cycle.
  assign core_stall = ~reset & core_req & ~core_rvalid & ~(core_win & core_we);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      owner_dbg   <= 1'b0;
      core_rvalid <= 1'b0;
      dbg_rvalid  <= 1'b0;
      core_rdata  <= '0;
      dbg_rdata   <= '0;
    end else begin
      core_rvalid <= 1'b0;
      dbg_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (dbg_win) begin
            starve_cnt <= '0;
          end else if (dbg_req && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
          if (mem_en && !mem_we) begin
            owner_dbg <= dbg_win;
            lat_cnt   <= 3'd1;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 3'(MEM_LAT)) begin
            if (owner_dbg) begin
              dbg_rdata  <= mem_rdata;
              dbg_rvalid <= 1'b1;
            end else begin
              core_rdata  <= mem_rdata;
              core_rvalid <= 1'b1;
            end
            lat_cnt <= '0;
            state   <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT 1, 2, 3) share one stimulus stream,
// each with its own memory and an abstract per-lane reference model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;

  logic        core_stall_w  [3];
  logic [31:0] core_rdata_w  [3];
  logic        core_rvalid_w [3];
  logic        dbg_gnt_w     [3];
  logic [31:0] dbg_rdata_w   [3];
  logic        dbg_rvalid_w  [3];
  logic        mem_en_w      [3];
  logic        mem_we_w      [3];
  logic [31:0] mem_addr_w    [3];
  logic [31:0] mem_wdata_w   [3];
  logic [31:0] mem_rdata_w   [3];
  logic        busy_w        [3];

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  // Lane k has read latency k+1; its memory returns data exactly k+1 cycles after a read strobe.
  for (genvar k = 0; k < 3; k++) begin : g_lane
    logic [31:0] mem  [16];
    logic [31:0] pipe [4];

    initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h1000 + i;
      mem[5] = 32'h1234;
      mem[2] = 32'hA5A5;
    end

    always @(posedge clk) begin
      if (mem_en_w[k] && mem_we_w[k]) mem[mem_addr_w[k][3:0]] <= mem_wdata_w[k];
      pipe[0] <= (mem_en_w[k] && !mem_we_w[k]) ? mem[mem_addr_w[k][3:0]] : 32'hBAD0_0000;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    assign mem_rdata_w[k] = pipe[k];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(k + 1), .STARVE_MAX(4)) u_dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_stall(core_stall_w[k]), .core_rdata(core_rdata_w[k]), .core_rvalid(core_rvalid_w[k]),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt_w[k]), .dbg_rdata(dbg_rdata_w[k]), .dbg_rvalid(dbg_rvalid_w[k]),
      .mem_en(mem_en_w[k]), .mem_we(mem_we_w[k]), .mem_addr(mem_addr_w[k]),
      .mem_wdata(mem_wdata_w[k]), .mem_rdata(mem_rdata_w[k]), .busy(busy_w[k])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic string nm(input int k, input string s);
    return $sformatf("lat%0d %s", k + 1, s);
  endfunction

  // Reference model: remaining read cycles, owner, expected data, starvation count, memory shadow.
  int          m_left   [3];
  bit          m_own    [3];
  logic [31:0] m_data   [3];
  bit          m_crv    [3];
  bit          m_drv    [3];
  logic [31:0] m_crd    [3];
  logic [31:0] m_drd    [3];
  int          m_starve [3];
  logic [31:0] m_mem    [3][16];

  bit          e_idle, e_ce, e_de, e_cw, e_dw, e_en, e_we, e_stall;
  logic [31:0] e_addr, e_wd;

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_left[k] = 0; m_own[k] = 1'b0; m_data[k] = '0; m_crv[k] = 1'b0; m_drv[k] = 1'b0;
      m_crd[k] = '0; m_drd[k] = '0; m_starve[k] = 0;
      for (int i = 0; i < 16; i++) m_mem[k][i] = 32'h1000 + i;
      m_mem[k][5] = 32'h1234;
      m_mem[k][2] = 32'hA5A5;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 3; k++) begin
        e_idle  = (m_left[k] == 0);
        e_ce    = !reset && e_idle && core_req && !m_crv[k];
        e_de    = !reset && e_idle && dbg_req;
        e_dw    = e_de && (!e_ce || m_starve[k] >= 4);
        e_cw    = e_ce && !e_dw;
        e_en    = e_cw || e_dw;
        e_we    = (e_cw && core_we) || (e_dw && dbg_we);
        e_addr  = e_dw ? dbg_addr : core_addr;
        e_wd    = e_dw ? dbg_wdata : core_wdata;
        e_stall = !reset && core_req && !m_crv[k] && !(e_cw && core_we);

        chk(nm(k, "mem_en"), 32'(mem_en_w[k]), 32'(e_en));
        chk(nm(k, "mem_we"), 32'(mem_we_w[k]), 32'(e_we));
        chk(nm(k, "dbg_gnt"), 32'(dbg_gnt_w[k]), 32'(e_dw));
        chk(nm(k, "core_stall"), 32'(core_stall_w[k]), 32'(e_stall));
        chk(nm(k, "busy"), 32'(busy_w[k]), 32'(!e_idle));
        chk(nm(k, "core_rvalid"), 32'(core_rvalid_w[k]), 32'(m_crv[k]));
        chk(nm(k, "dbg_rvalid"), 32'(dbg_rvalid_w[k]), 32'(m_drv[k]));
        chk(nm(k, "core_rdata"), core_rdata_w[k], m_crd[k]);
        chk(nm(k, "dbg_rdata"), dbg_rdata_w[k], m_drd[k]);
        if (e_en) begin
          chk(nm(k, "mem_addr"), mem_addr_w[k], e_addr);
          chk(nm(k, "mem_wdata"), mem_wdata_w[k], e_wd);
        end

        if (reset) begin
          m_left[k] = 0; m_starve[k] = 0; m_crv[k] = 1'b0; m_drv[k] = 1'b0;
          m_crd[k] = '0; m_drd[k] = '0;
        end else begin
          m_crv[k] = 1'b0;
          m_drv[k] = 1'b0;
          if (!e_idle) begin
            if (m_left[k] == 1) begin
              if (m_own[k]) begin m_drv[k] = 1'b1; m_drd[k] = m_data[k]; end
              else          begin m_crv[k] = 1'b1; m_crd[k] = m_data[k]; end
            end
            m_left[k]--;
          end else begin
            if (e_dw) m_starve[k] = 0;
            else if (dbg_req && m_starve[k] < 4) m_starve[k]++;
            if (e_en) begin
              if (e_we) m_mem[k][e_addr[3:0]] = e_wd;
              else begin
                m_left[k] = k + 1;
                m_own[k]  = e_dw;
                m_data[k] = m_mem[k][e_addr[3:0]];
              end
            end
          end
        end
      end
    end
  end

  task automatic set_in(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    dbg_req  = dr; dbg_we  = dw; dbg_addr  = da; dbg_wdata  = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    set_in(1, 0, 5, 0, 1, 1, 3, 32'h77);
    tick();
    run = 1'b1;
    @(negedge clk);
    chk("reset mem_en", 32'(mem_en_w[0]), 0);
    chk("reset dbg_gnt", 32'(dbg_gnt_w[0]), 0);
    chk("reset core_stall", 32'(core_stall_w[0]), 0);
    chk("reset busy", 32'(busy_w[0]), 0);
    chk("reset core_rdata", core_rdata_w[0], 0);
    tick();
    reset = 1'b0;
    idle_cycles(1);

    // Core read of address 5 on the latency-1 lane.
    set_in(1, 0, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rd t mem_en", 32'(mem_en_w[0]), 1);
    chk("rd t mem_addr", mem_addr_w[0], 5);
    chk("rd t core_stall", 32'(core_stall_w[0]), 1);
    tick();
    @(negedge clk);
    chk("rd t+1 core_stall", 32'(core_stall_w[0]), 1);
    chk("rd t+1 busy", 32'(busy_w[0]), 1);
    tick();
    @(negedge clk);
    chk("rd t+2 core_rvalid", 32'(core_rvalid_w[0]), 1);
    chk("rd t+2 core_rdata", core_rdata_w[0], 32'h1234);
    chk("rd t+2 core_stall", 32'(core_stall_w[0]), 0);
    chk("rd t+2 no reissue", 32'(mem_en_w[0]), 0);
    tick();
    idle_cycles(3);

    // Core write.
    set_in(1, 1, 7, 32'hDEAD, 0, 0, 0, 0);
    @(negedge clk);
    chk("wr mem_en", 32'(mem_en_w[0]), 1);
    chk("wr mem_we", 32'(mem_we_w[0]), 1);
    chk("wr mem_addr", mem_addr_w[0], 7);
    chk("wr mem_wdata", mem_wdata_w[0], 32'hDEAD);
    chk("wr core_stall", 32'(core_stall_w[0]), 0);
    chk("wr busy", 32'(busy_w[0]), 0);
    tick();
    idle_cycles(1);

    // Simultaneous core read and dbg write.
    set_in(1, 0, 7, 0, 1, 1, 9, 32'hBEEF);
    @(negedge clk);
    chk("sim s mem_addr", mem_addr_w[0], 7);
    chk("sim s dbg_gnt", 32'(dbg_gnt_w[0]), 0);
    tick();
    @(negedge clk);
    chk("sim s+1 dbg_gnt", 32'(dbg_gnt_w[0]), 0);
    tick();
    @(negedge clk);
    chk("sim s+2 core_rdata", core_rdata_w[0], 32'hDEAD);
    chk("sim s+2 dbg_gnt", 32'(dbg_gnt_w[0]), 1);
    chk("sim s+2 mem_addr", mem_addr_w[0], 9);
    chk("sim s+2 mem_wdata", mem_wdata_w[0], 32'hBEEF);
    tick();
    idle_cycles(3);

    // Starvation: back-to-back core writes with dbg held.
    for (int i = 1; i <= 5; i++) begin
      set_in(1, 1, 11, 32'h100 + i, 1, 1, 10, 32'h5555);
      @(negedge clk);
      chk($sformatf("starve c%0d dbg_gnt", i), 32'(dbg_gnt_w[0]), 32'(i == 5));
      chk($sformatf("starve c%0d core_stall", i), 32'(core_stall_w[0]), 32'(i == 5));
      tick();
    end
    set_in(1, 1, 11, 32'h106, 0, 0, 0, 0);
    tick();
    set_in(1, 1, 11, 32'h107, 1, 1, 10, 32'h6666);
    @(negedge clk);
    chk("starve cleared dbg_gnt", 32'(dbg_gnt_w[0]), 0);
    tick();
    idle_cycles(1);

    // Dbg read on the latency-3 lane.
    set_in(0, 0, 0, 0, 1, 0, 2, 0);
    @(negedge clk);
    chk("dbgrd u dbg_gnt", 32'(dbg_gnt_w[2]), 1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("dbgrd u+%0d busy", i), 32'(busy_w[2]), 1);
      tick();
    end
    @(negedge clk);
    chk("dbgrd u+4 dbg_rvalid", 32'(dbg_rvalid_w[2]), 1);
    chk("dbgrd u+4 dbg_rdata", dbg_rdata_w[2], 32'hA5A5);
    chk("dbgrd u+4 core_rvalid", 32'(core_rvalid_w[2]), 0);
    tick();
    idle_cycles(1);

    // Reset in the middle of a core read on the latency-2 lane.
    set_in(1, 0, 5, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rstrd v+1 core_stall", 32'(core_stall_w[1]), 0);
    chk("rstrd v+1 mem_en", 32'(mem_en_w[1]), 0);
    tick();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rstrd v+2 busy", 32'(busy_w[1]), 0);
    chk("rstrd v+2 core_rdata", core_rdata_w[1], 0);
    chk("rstrd v+2 mem_en", 32'(mem_en_w[1]), 0);
    chk("rstrd v+2 dbg_gnt", 32'(dbg_gnt_w[1]), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rstrd after %0d core_rvalid", i), 32'(core_rvalid_w[1]), 0);
      tick();
      @(negedge clk);
    end
    tick();

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage ("core") and a debug/DMA loader port ("dbg").
- Sequences fixed-latency reads, issues single-cycle writes, and drives the core stall.
- The core stall feeds the hazard unit so the pipeline freezes while a core access is not yet complete.
- Sits between the MEM-stage pipeline registers and the main memory instance.

Parameters:
ADDR_W, 32, word-address width driven to memory
DATA_W, 32, data width
MEM_LAT, 1, cycles from read issue (mem_en) to mem_rdata valid; legal range 1..4
STARVE_MAX, 4, number of denied IDLE cycles after which dbg outranks core

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
core_req  in  1  core access request; held until completion
core_we  in  1  1 = write, 0 = read
core_addr  in  ADDR_W  core word address
core_wdata  in  DATA_W  core write data
core_stall  out  1  core access not complete this cycle (combinational)
core_rdata  out  DATA_W  registered core read data
core_rvalid  out  1  one-cycle pulse; core_rdata valid
dbg_req  in  1  debug access request; held until dbg_gnt
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  ADDR_W  debug word address
dbg_wdata  in  DATA_W  debug write data
dbg_gnt  out  1  one-cycle pulse; debug request accepted (combinational)
dbg_rdata  out  DATA_W  registered debug read data
dbg_rvalid  out  1  one-cycle pulse; dbg_rdata valid
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable; only ever high together with mem_en
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after mem_en
busy  out  1  state is not IDLE

Behaviour:
- Reset values: state IDLE, lat_cnt 0, starve_cnt 0, owner core, core_rvalid 0, dbg_rvalid 0, core_rdata 0, dbg_rdata 0.
- With reset high, mem_en, mem_we, dbg_gnt and core_stall are all 0.
- States:
  - IDLE: arbitrates.
  - RD_WAIT: read outstanding; lat_cnt counts 1..MEM_LAT.
- Arbitration happens in IDLE only.
  - Core is eligible when core_req=1 and core_rvalid=0. This prevents re-issue in the completion cycle.
  - Dbg is eligible when dbg_req=1.
  - Both eligible: core wins, unless starve_cnt >= STARVE_MAX, in which case dbg wins.
- Grant cycle:
  - mem_en=1; mem_addr and mem_wdata taken from the winner; mem_we = winner's we.
  - For a dbg grant, dbg_gnt=1.
- Write grant: completes in the grant cycle and state stays IDLE. No rvalid is produced for writes.
- Read grant: owner is recorded, lat_cnt is set to 1, and state moves to RD_WAIT.
- RD_WAIT:
  - mem_en=0.
  - When lat_cnt == MEM_LAT: mem_rdata is captured into the owner's rdata register, the owner's rvalid is set for the next cycle, and state returns to IDLE. Otherwise lat_cnt increments.
  - Read latency from grant cycle t: rvalid high in cycle t+MEM_LAT+1. That cycle is IDLE, so a new grant is possible in it.
- core_stall = core_req & ~core_rvalid & ~(core write granted this cycle).
  - Reads stall until the rvalid cycle.
  - Writes stall only while waiting for grant.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) in each IDLE cycle where dbg_req=1 and dbg is not granted.
  - Clears on dbg grant.
  - Holds in RD_WAIT.
- rvalid pulses last exactly one cycle. rdata registers hold their value until the next capture.
- If a requester drops its request before grant, it is simply not served. No error is raised.
- Reset asserted mid-read: the transaction is abandoned, no rvalid is produced, and all state returns to reset values on that edge.
- Requests asserted in the same cycle reset deasserts are not granted until the following cycle.

Test Plan:
- Core read, MEM_LAT=1: mem holds 0x1234 at addr 5; core_req=1, we=0, addr 5 at cycle t -> mem_en=1 at t, core_stall=1 at t and t+1, core_rvalid=1 with core_rdata=0x1234 at t+2, core_stall=0 at t+2, no re-issue at t+2.
- Core write: core_req=1, we=1, addr 7, wdata 0xDEAD in IDLE -> mem_en=mem_we=1 with addr 7 the same cycle, core_stall=0, busy stays 0.
- Simultaneous requests, starve_cnt=0: core read and dbg write in the same cycle -> core granted first; dbg_gnt pulses in the rvalid cycle of the core read, or the first IDLE cycle where core is not eligible.
- Starvation, STARVE_MAX=4: core issues back-to-back writes every cycle with dbg_req held -> dbg_gnt on the 5th IDLE cycle and core_stall=1 that cycle; starve_cnt reads 0 afterwards.
- MEM_LAT=3 dbg read: dbg read at addr 2 (data 0xA5A5) at t -> busy high t+1..t+3, dbg_rvalid=1 with dbg_rdata=0xA5A5 at t+4, core_rvalid stays 0.
- Reset mid-read: reset=1 at t+1 of a core read with MEM_LAT=2 -> no core_rvalid ever produced, busy=0 and all outputs 0 at t+2.
